// File: rtl/div_iter_pkg.sv
// rtl/div_iter_pkg.sv - shared state encoding, handshake constants and helpers for div_iter.
package div_iter_pkg;

  localparam logic [1:0]  DivFree           = 2'b00;
  localparam logic [1:0]  DivByZero         = 2'b01;
  localparam logic [1:0]  DivOn             = 2'b10;
  localparam logic [1:0]  DivEnd            = 2'b11;
  localparam logic        DivStart          = 1'b1;
  localparam logic        DivStop           = 1'b0;
  localparam logic        DivResultReady    = 1'b1;
  localparam logic        DivResultNotReady = 1'b0;
  localparam logic [31:0] ZeroWord          = 32'h0000_0000;
  localparam logic [31:0] AllOnesWord       = 32'hFFFF_FFFF;
  localparam logic [5:0]  LastIter          = 6'd31;

  typedef enum logic [1:0] {
    DIV_FREE   = DivFree,
    DIV_BYZERO = DivByZero,
    DIV_ON     = DivOn,
    DIV_END    = DivEnd
  } div_state_e;

  // 0x80000000 negates to itself, which is the correct unsigned magnitude.
  function automatic logic [31:0] abs_mag(input logic [31:0] v, input logic neg);
    abs_mag = neg ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one restoring-division step: 33-bit trial subtract of the divisor, restore on borrow.
module div_step (
  input  logic [32:0] part_i,
  input  logic [31:0] divisor_i,
  output logic [31:0] rem_o,
  output logic        q_bit_o
);

  logic [31:0] diff;

  always_comb begin
    q_bit_o = (part_i >= {1'b0, divisor_i});
    // Only consumed when no borrow, so the result always fits in 32 bits.
    diff    = part_i[31:0] - divisor_i;
    rem_o   = q_bit_o ? diff : part_i[31:0];
  end

endmodule

// File: rtl/div_iter.sv
// rtl/div_iter.sv - iterative radix-2 restoring DIV/DIVU responder for the EX divide handshake.
// Optional DIV_EARLY_FINISH_EN: skip the iterations when |dividend| < |divisor|.
module div_iter
  import div_iter_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        signed_div_i,
  input  logic [31:0] opdata1_i,
  input  logic [31:0] opdata2_i,
  input  logic        start_i,
  input  logic        annul_i,
  output logic [63:0] result_o,
  output logic        ready_o
);

  div_state_e  state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [63:0] wreg_q, wreg_d;
  logic [31:0] divisor_q, divisor_d;
  logic [31:0] dividend_q, dividend_d;
  logic        sign_en_q, sign_en_d;
  logic        neg1_q, neg1_d;
  logic        neg2_q, neg2_d;
  logic        early_q, early_d;
  logic [63:0] result_q, result_d;
  logic        ready_q, ready_d;

  logic [31:0] mag1, mag2;
  logic        op_neg1, op_neg2;
  logic        early_hit;
  logic        accept;
  logic        abort;
  logic [31:0] step_rem;
  logic        step_qbit;
  logic [63:0] wreg_next;
  logic [31:0] quot_fix, rem_fix;

  div_step u_step (
    .part_i    (wreg_q[63:31]),
    .divisor_i (divisor_q),
    .rem_o     (step_rem),
    .q_bit_o   (step_qbit)
  );

  always_comb begin
    op_neg1   = signed_div_i & opdata1_i[31];
    op_neg2   = signed_div_i & opdata2_i[31];
    mag1      = abs_mag(opdata1_i, op_neg1);
    mag2      = abs_mag(opdata2_i, op_neg2);
`ifdef DIV_EARLY_FINISH_EN
    early_hit = (opdata2_i != ZeroWord) && (mag1 < mag2);
`else
    early_hit = 1'b0;
`endif
    accept    = (start_i == DivStart) && !annul_i;
    abort     = annul_i || (start_i == DivStop);

    wreg_next = {step_rem, wreg_q[30:0], step_qbit};
    quot_fix  = (sign_en_q && (neg1_q ^ neg2_q)) ? -wreg_next[31:0] : wreg_next[31:0];
    rem_fix   = (sign_en_q && neg1_q) ? -wreg_next[63:32] : wreg_next[63:32];
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    wreg_d     = wreg_q;
    divisor_d  = divisor_q;
    dividend_d = dividend_q;
    sign_en_d  = sign_en_q;
    neg1_d     = neg1_q;
    neg2_d     = neg2_q;
    early_d    = early_q;
    result_d   = result_q;
    ready_d    = DivResultNotReady;

    case (state_q)
      DIV_FREE: begin
        if (accept) begin
          dividend_d = opdata1_i;
          divisor_d  = mag2;
          wreg_d     = {ZeroWord, mag1};
          sign_en_d  = signed_div_i;
          neg1_d     = op_neg1;
          neg2_d     = op_neg2;
          cnt_d      = 6'd0;
          early_d    = 1'b0;
          if (opdata2_i == ZeroWord) begin
            state_d = DIV_BYZERO;
          end else if (early_hit) begin
            // Shares the one-cycle BYZERO path; only the quotient differs.
            state_d = DIV_BYZERO;
            early_d = 1'b1;
          end else begin
            state_d = DIV_ON;
          end
        end
      end

      DIV_BYZERO: begin
        if (abort) begin
          state_d = DIV_FREE;
        end else begin
          state_d  = DIV_END;
          ready_d  = DivResultReady;
          result_d = {dividend_q, early_q ? ZeroWord : AllOnesWord};
        end
      end

      DIV_ON: begin
        if (abort) begin
          state_d = DIV_FREE;
        end else begin
          wreg_d = wreg_next;
          cnt_d  = cnt_q + 6'd1;
          if (cnt_q == LastIter) begin
            state_d  = DIV_END;
            ready_d  = DivResultReady;
            result_d = {rem_fix, quot_fix};
          end
        end
      end

      DIV_END: begin
        // start_i is ignored here so a held request cannot retrigger on a stale pulse.
        state_d = DIV_FREE;
      end

      default: begin
        state_d = DIV_FREE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= DIV_FREE;
      cnt_q      <= 6'd0;
      wreg_q     <= {ZeroWord, ZeroWord};
      divisor_q  <= ZeroWord;
      dividend_q <= ZeroWord;
      sign_en_q  <= 1'b0;
      neg1_q     <= 1'b0;
      neg2_q     <= 1'b0;
      early_q    <= 1'b0;
      result_q   <= {ZeroWord, ZeroWord};
      ready_q    <= DivResultNotReady;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      wreg_q     <= wreg_d;
      divisor_q  <= divisor_d;
      dividend_q <= dividend_d;
      sign_en_q  <= sign_en_d;
      neg1_q     <= neg1_d;
      neg2_q     <= neg2_d;
      early_q    <= early_d;
      result_q   <= result_d;
      ready_q    <= ready_d;
    end
  end

  assign result_o = result_q;
  assign ready_o  = ready_q;

endmodule

// File: tb/tb_div_iter.sv
// tb/tb_div_iter.sv - randomized self-checking bench for div_iter against an arithmetic reference.
module tb_div_iter;

  logic        clk = 1'b0;
  logic        rst;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        start_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;

  int checks = 0;
  int errors = 0;

  div_iter dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] ref_div(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    int sa, sb;
    logic [31:0] q, r;
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    if (!sgn) begin
      q = a / b;
      r = a % b;
      return {r, q};
    end
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
    sa = $signed(a);
    sb = $signed(b);
    q = sa / sb;
    r = sa % sb;
    return {r, q};
  endfunction

  function automatic logic [31:0] ref_mag(input logic sgn, input logic [31:0] v);
    if (sgn && v[31]) return 32'd0 - v;
    return v;
  endfunction

  function automatic int ref_lat(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    if (b == 32'd0) return 1;
`ifdef DIV_EARLY_FINISH_EN
    if (ref_mag(sgn, a) < ref_mag(sgn, b)) return 1;
`endif
    return 32;
  endfunction

  // Caller is positioned just after a rising edge with the divider idle.
  task automatic run_op(input string name, input logic sgn, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] exp_res;
    int          exp_lat;
    int          lat;
    int          k;
    exp_res      = ref_div(sgn, a, b);
    exp_lat      = ref_lat(sgn, a, b);
    signed_div_i = sgn;
    opdata1_i    = a;
    opdata2_i    = b;
    start_i      = 1'b1;
    @(posedge clk); #1;
    opdata1_i    = $urandom;
    opdata2_i    = $urandom;
    signed_div_i = ~sgn;
    lat = 0;
    k   = 0;
    while (lat == 0 && k < 60) begin
      @(posedge clk); #1;
      k++;
      if (ready_o === 1'b1) lat = k;
    end
    start_i = 1'b0;
    checks++;
    if (lat !== exp_lat) begin
      errors++;
      $display("FAIL %s latency: got %0d expected %0d (a=%h b=%h s=%0d)", name, lat, exp_lat, a, b, sgn);
    end
    checks++;
    if (result_o !== exp_res) begin
      errors++;
      $display("FAIL %s result: got %h expected %h (a=%h b=%h s=%0d)", name, result_o, exp_res, a, b, sgn);
    end
    @(posedge clk); #1;
    checks++;
    if (ready_o !== 1'b0 || result_o !== exp_res) begin
      errors++;
      $display("FAIL %s after_pulse: ready=%b result=%h expected ready=0 result=%h", name, ready_o, result_o, exp_res);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; signed_div_i = 1'b0; opdata1_i = '0; opdata2_i = '0; start_i = 1'b0; annul_i = 1'b0;
    #3;
    checks++;
    if (ready_o !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", ready_o); end
    checks++;
    if (result_o !== 64'd0) begin errors++; $display("FAIL reset_result: got %h expected 0", result_o); end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_unsigned();
    run_op("divu_100_7", 1'b0, 32'd100, 32'd7);
    checks++;
    if (result_o !== {32'd2, 32'd14}) begin
      errors++; $display("FAIL divu_100_7_const: got %h expected %h", result_o, {32'd2, 32'd14});
    end
    for (int i = 0; i < 6; i++) run_op("divu_rand", 1'b0, $urandom, $urandom >> $urandom_range(0, 31));
    run_op("divu_max", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op("divu_big_divisor", 1'b0, 32'hFFFF_FFFF, 32'h8000_0001);
  endtask

  task automatic test_signed();
    run_op("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2);
    checks++;
    if (result_o !== {32'hFFFF_FFFF, 32'hFFFF_FFFD}) begin
      errors++; $display("FAIL div_m7_2_const: got %h expected ffffffff_fffffffd", result_o);
    end
    run_op("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE);
    checks++;
    if (result_o !== {32'h0000_0001, 32'hFFFF_FFFD}) begin
      errors++; $display("FAIL div_7_m2_const: got %h expected 00000001_fffffffd", result_o);
    end
    run_op("div_overflow", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    checks++;
    if (result_o !== {32'd0, 32'h8000_0000}) begin
      errors++; $display("FAIL div_overflow_const: got %h expected 00000000_80000000", result_o);
    end
    run_op("div_minint_minint", 1'b1, 32'h8000_0000, 32'h8000_0000);
    for (int i = 0; i < 6; i++) run_op("div_rand", 1'b1, $urandom, $urandom >> $urandom_range(0, 31));
  endtask

  task automatic test_divzero();
    run_op("divu_by_zero", 1'b0, 32'd5, 32'd0);
    run_op("div_by_zero", 1'b1, 32'd5, 32'd0);
    checks++;
    if (result_o !== {32'd5, 32'hFFFF_FFFF}) begin
      errors++; $display("FAIL div_by_zero_const: got %h expected 00000005_ffffffff", result_o);
    end
    run_op("div_neg_by_zero", 1'b1, 32'hFFFF_FFF0, 32'd0);
  endtask

  task automatic test_early();
    run_op("divu_3_9", 1'b0, 32'd3, 32'd9);
    checks++;
    if (result_o !== {32'd3, 32'd0}) begin
      errors++; $display("FAIL divu_3_9_const: got %h expected 00000003_00000000", result_o);
    end
    run_op("div_m3_9", 1'b1, 32'hFFFF_FFFD, 32'd9);
    run_op("div_3_m9", 1'b1, 32'd3, 32'hFFFF_FFF7);
  endtask

  task automatic test_abort();
    logic [63:0] prev;
    bit          saw_ready;
    bit          changed;
    prev = result_o;
    signed_div_i = 1'b0; opdata1_i = 32'd1000; opdata2_i = 32'd3; start_i = 1'b1;
    @(posedge clk); #1;
    repeat (9) begin @(posedge clk); #1; end
    annul_i = 1'b1;
    @(posedge clk); #1;
    annul_i = 1'b0;
    start_i = 1'b0;
    saw_ready = 1'b0;
    changed   = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (ready_o !== 1'b0) saw_ready = 1'b1;
      if (result_o !== prev) changed = 1'b1;
    end
    checks++;
    if (saw_ready) begin errors++; $display("FAIL abort_no_ready: got ready pulse expected none"); end
    checks++;
    if (changed) begin errors++; $display("FAIL abort_result_held: got %h expected %h", result_o, prev); end
    run_op("after_abort", 1'b0, 32'd1000, 32'd3);
  endtask

  task automatic test_rst_midop();
    signed_div_i = 1'b1; opdata1_i = 32'hFFFF_0000; opdata2_i = 32'd17; start_i = 1'b1;
    @(posedge clk); #1;
    repeat (19) begin @(posedge clk); #1; end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (ready_o !== 1'b0 || result_o !== 64'd0) begin
      errors++; $display("FAIL rst_midop: ready=%b result=%h expected ready=0 result=0", ready_o, result_o);
    end
    start_i = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    run_op("after_rst", 1'b1, 32'hFFFF_0000, 32'd17);
  endtask

  task automatic test_back_to_back();
    logic [63:0] r1, r2;
    int          lat1, lat2, k;
    r1 = ref_div(1'b0, 32'd100, 32'd7);
    r2 = ref_div(1'b0, 32'hDEAD_BEEF, 32'h0000_1234);
    signed_div_i = 1'b0; opdata1_i = 32'd100; opdata2_i = 32'd7; start_i = 1'b1;
    @(posedge clk); #1;
    lat1 = 0; k = 0;
    while (lat1 == 0 && k < 60) begin
      @(posedge clk); #1;
      k++;
      if (ready_o === 1'b1) lat1 = k;
    end
    checks++;
    if (lat1 !== 32 || result_o !== r1) begin
      errors++; $display("FAIL b2b_first: lat=%0d result=%h expected lat=32 result=%h", lat1, result_o, r1);
    end
    opdata1_i = 32'hDEAD_BEEF; opdata2_i = 32'h0000_1234;
    lat2 = 0; k = 0;
    while (lat2 == 0 && k < 60) begin
      @(posedge clk); #1;
      k++;
      if (k == 1) begin
        checks++;
        if (ready_o !== 1'b0 || result_o !== r1) begin
          errors++; $display("FAIL b2b_gap: ready=%b result=%h expected ready=0 result=%h", ready_o, result_o, r1);
        end
      end
      if (ready_o === 1'b1) lat2 = k;
    end
    start_i = 1'b0;
    checks++;
    if (lat2 !== 34 || result_o !== r2) begin
      errors++; $display("FAIL b2b_second: lat=%0d result=%h expected lat=34 result=%h", lat2, result_o, r2);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_divzero();
    test_early();
    test_abort();
    test_rst_midop();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
